patch_mac: RTL and testbench

Fixed-point dot-product stage that sits directly downstream of `im2col`. It accepts one flattened kernel-sized patch together with a matching weight vector and accumulates their products over several cycles, `LANES` multiply-accumulates per cycle. It then rounds and saturates the sum back to the shared Q(IL).(FL) format and presents it on a valid/ready output. Patches and weights use the same element layout and precision as the `im2col` output.

---
 rtl/patch_mac.sv | 155 +++++++++++++++
 tb/tb_patch_mac.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/patch_mac.sv
// ============================================================================
// patch_mac : LANES-wide fixed-point dot product of an im2col patch and a
//             weight vector, rounded half-up and saturated to Q(IL).(FL).
// Revision  : 1.0
// ============================================================================
`default_nettype none

module patch_mac #(
   parameter int IL    = 4,
   parameter int FL    = 16,
   parameter int k     = 16,
   parameter int LANES = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic signed [IL+FL-1:0]     patch  [k*k],
   input  logic signed [IL+FL-1:0]     weight [k*k],
   input  logic        [$clog2(k)-1:0] k_h,
   input  logic        [$clog2(k)-1:0] k_w,
   input  logic                        patch_valid,
   output logic                        patch_ready,
   output logic signed [IL+FL-1:0]     result,
   output logic                        result_valid,
   input  logic                        result_ready,
   output logic                        busy
);

   localparam int DW = IL + FL;
   localparam int PW = 2 * DW;
   localparam int NE = k * k;
   localparam int AW = PW + $clog2(NE);
   localparam int NW = $clog2(NE) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_ROUND = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   localparam logic signed [AW-1:0] C_HALF = {{(AW-FL){1'b0}}, 1'b1, {(FL-1){1'b0}}};
   localparam logic signed [AW-1:0] C_MAX  = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] C_MIN  = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   logic [1:0]              state_q, state_d;
   logic signed [AW-1:0]    acc_q, acc_d;
   logic [NW-1:0]           g_q, g_d;
   logic [NW-1:0]           n_q, n_d;
   logic signed [DW-1:0]    res_q, res_d;
   logic                    rv_q, rv_d;
   logic signed [DW-1:0]    patch_q  [NE];
   logic signed [DW-1:0]    weight_q [NE];

   logic                    accept;
   logic [NW-1:0]           base;
   logic [NW-1:0]           lane_idx;
   logic signed [PW-1:0]    prod;
   logic signed [AW-1:0]    acc_sum;
   logic signed [AW-1:0]    rounded;
   logic signed [DW-1:0]    saturated;

   assign patch_ready  = (state_q == S_IDLE) && !reset;
   assign busy         = (state_q != S_IDLE);
   assign result       = res_q;
   assign result_valid = rv_q;
   assign accept       = patch_valid && (state_q == S_IDLE);
   assign base         = g_q * NW'(LANES);

   // Elements at or beyond n are skipped, so stale data past the kernel never contributes.
   always_comb begin
      acc_sum  = acc_q;
      lane_idx = '0;
      prod     = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_idx = base + NW'(l);
         if (lane_idx < n_q) begin
            prod    = patch_q[lane_idx[NW-2:0]] * weight_q[lane_idx[NW-2:0]];
            acc_sum = acc_sum + {{(AW-PW){prod[PW-1]}}, prod};
         end
      end
   end

   always_comb begin
      rounded = (acc_q + C_HALF) >>> FL;
      if (rounded > C_MAX)
         saturated = C_MAX[DW-1:0];
      else if (rounded < C_MIN)
         saturated = C_MIN[DW-1:0];
      else
         saturated = rounded[DW-1:0];
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      g_d     = g_q;
      n_d     = n_q;
      res_d   = res_q;
      rv_d    = rv_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               n_d     = NW'(k_h) * NW'(k_w);
               acc_d   = '0;
               g_d     = '0;
               state_d = (n_d != '0) ? S_ACCUM : S_ROUND;
            end
         end
         S_ACCUM: begin
            acc_d = acc_sum;
            g_d   = g_q + 1'b1;
            if ((base + NW'(LANES)) >= n_q)
               state_d = S_ROUND;
         end
         S_ROUND: begin
            res_d   = saturated;
            rv_d    = 1'b1;
            state_d = S_HOLD;
         end
         default: begin
            if (result_ready) begin
               rv_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         g_q     <= '0;
         n_q     <= '0;
         res_q   <= '0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         g_q     <= g_d;
         n_q     <= n_d;
         res_q   <= res_d;
         rv_q    <= rv_d;
      end
   end

   // Operands are captured once at acceptance; the ports may change freely afterwards.
   always_ff @(posedge clk) begin
      if (accept && !reset) begin
         patch_q  <= patch;
         weight_q <= weight;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_patch_mac.sv
// ============================================================================
// tb_patch_mac : directed self-checking bench for patch_mac.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_patch_mac;

   localparam int IL    = 4;
   localparam int FL    = 16;
   localparam int K     = 16;
   localparam int LANES = 4;
   localparam int DW    = IL + FL;
   localparam int NE    = K * K;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic signed [DW-1:0] patch  [NE];
   logic signed [DW-1:0] weight [NE];
   logic [3:0]           k_h = '0;
   logic [3:0]           k_w = '0;
   logic                 patch_valid = 1'b0;
   logic                 patch_ready;
   logic signed [DW-1:0] result;
   logic                 result_valid;
   logic                 result_ready = 1'b1;
   logic                 busy;

   int n_tests = 0;
   int n_fail  = 0;
   int lat;

   always #5 clk = ~clk;

   patch_mac #(.IL(IL), .FL(FL), .k(K), .LANES(LANES)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .patch        (patch),
      .weight       (weight),
      .k_h          (k_h),
      .k_w          (k_w),
      .patch_valid  (patch_valid),
      .patch_ready  (patch_ready),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .busy         (busy)
   );

   task automatic check_eq(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic fill_all(input int p, input int w);
      for (int i = 0; i < NE; i++) begin
         patch[i]  = DW'(p);
         weight[i] = DW'(w);
      end
   endtask

   task automatic wait_valid(output int cycles);
      cycles = 0;
      while (!result_valid && cycles < 50) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic run_op(input string tag, input int kh, input int kw,
                         input int exp_res, input int exp_lat);
      int l;
      k_h          = 4'(kh);
      k_w          = 4'(kw);
      result_ready = 1'b1;
      patch_valid  = 1'b1;
      @(posedge clk); #1;
      patch_valid = 1'b0;
      wait_valid(l);
      check_eq({tag, "_lat"}, l, exp_lat);
      check_eq({tag, "_res"}, result, exp_res);
      @(posedge clk); #1;
      check_eq({tag, "_pulse"}, result_valid, 0);
   endtask

   initial begin
      fill_all(0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ready", patch_ready, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_valid", result_valid, 0);
      check_eq("rst_result", result, 0);
      reset = 1'b0;
      #1;
      check_eq("idle_ready", patch_ready, 1);

      // 9 x 0.5 x 1.0 = 4.5
      fill_all(32768, 65536);
      run_op("round_pos", 3, 3, 294912, 4);

      fill_all(65536, 65536);
      run_op("sat_pos", 3, 3, 524287, 4);
      fill_all(-65536, 65536);
      run_op("sat_neg", 3, 3, -524288, 4);

      fill_all(1, 32768);
      run_op("half_up", 1, 1, 1, 2);
      fill_all(-1, 32768);
      run_op("half_neg", 1, 1, 0, 2);
      fill_all(3, 16384);
      run_op("three_q", 1, 1, 1, 2);

      // Inactive tail filled with large values that must be masked out
      fill_all(524287, 524287);
      for (int i = 0; i < 6; i++) begin
         patch[i]  = DW'(65536);
         weight[i] = DW'(65536);
      end
      run_op("mask", 2, 3, 393216, 3);

      fill_all(65536, 65536);
      run_op("n_zero", 0, 3, 0, 1);

      // Backpressure: result held while a competing patch_valid is offered
      fill_all(32768, 65536);
      k_h          = 4'd3;
      k_w          = 4'd3;
      result_ready = 1'b0;
      patch_valid  = 1'b1;
      @(posedge clk); #1;
      patch_valid = 1'b0;
      wait_valid(lat);
      check_eq("bp_lat", lat, 4);
      check_eq("bp_res", result, 294912);
      fill_all(65536, 65536);
      k_h         = 4'd1;
      k_w         = 4'd1;
      patch_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check_eq("bp_hold_res", result, 294912);
         check_eq("bp_hold_valid", result_valid, 1);
         check_eq("bp_hold_ready", patch_ready, 0);
      end
      patch_valid  = 1'b0;
      result_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("bp_release_valid", result_valid, 0);
      check_eq("bp_release_ready", patch_ready, 1);
      check_eq("bp_release_busy", busy, 0);
      run_op("after_bp", 1, 1, 65536, 2);

      // Reset during the second ACCUM cycle of a saturating op
      fill_all(65536, 65536);
      k_h         = 4'd3;
      k_w         = 4'd3;
      patch_valid = 1'b1;
      @(posedge clk); #1;
      patch_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_valid", result_valid, 0);
      check_eq("mid_rst_ready", patch_ready, 1);
      fill_all(32768, 65536);
      run_op("post_rst", 3, 3, 294912, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
